// File: rtl/blit_pkg.sv
// rtl/blit_pkg.sv - blit descriptor layout, command codes and scheduler state encoding
package blit_pkg;

    localparam int BLIT_DESC_W = 229;

    localparam logic [4:0] NOP  = 5'd0;
    localparam logic [4:0] RECT = 5'd1;
    localparam logic [4:0] COPY = 5'd2;
    localparam logic [4:0] TEXT = 5'd3;

    typedef struct packed {
        logic [4:0]  command;
        logic [15:0] x1;
        logic [15:0] y1;
        logic [15:0] x2;
        logic [15:0] y2;
        logic [15:0] src_x;
        logic [15:0] src_y;
        logic [31:0] src_dx_x;
        logic [31:0] src_dy_y;
        logic [31:0] src_dy_x;
        logic [31:0] src_dx_y;
    } blit_desc_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/blit_cmd_scheduler_if.sv
// rtl/blit_cmd_scheduler_if.sv - requester and coordinate-generator handshake bundle
interface blit_cmd_scheduler_if #(parameter int NUM_REQ = 2);
    import blit_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*BLIT_DESC_W-1:0] req_desc;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             done;
    logic                           sched_busy;
    logic                           gen_start;
    logic                           gen_ack;
    logic                           gen_busy;
    logic                           gen_pipe_idle;
    logic [BLIT_DESC_W-1:0]         gen_desc;

    modport slave (
        input  req_valid, req_desc, gen_ack, gen_busy, gen_pipe_idle,
        output req_ready, done, sched_busy, gen_start, gen_desc
    );

    modport master (
        output req_valid, req_desc, gen_ack, gen_busy, gen_pipe_idle,
        input  req_ready, done, sched_busy, gen_start, gen_desc
    );

endinterface

// File: rtl/blit_rr_arbiter.sv
// rtl/blit_rr_arbiter.sv - round-robin grant from ptr upward; BLIT_SCHED_PRIORITY_EN gives req 0 strict priority
module blit_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      grant_idx
);

    logic [NUM_REQ-1:0] cand;
    logic [PW-1:0]      idx;
    logic               found;

    always_comb begin
        cand = req;
`ifdef BLIT_SCHED_PRIORITY_EN
        // Requester 0 pre-empts the rotation; otherwise bit 0 is already clear.
        if (req[0]) cand = NUM_REQ'(1);
`endif
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!found && cand[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/blit_cmd_scheduler.sv
// rtl/blit_cmd_scheduler.sv - blit command arbitration and generator sequencing; BLIT_SCHED_PRIORITY_EN selects req-0 priority
module blit_cmd_scheduler
    import blit_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int WAIT_DRAIN = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    blit_cmd_scheduler_if.slave  bus
);

    localparam int PW = $clog2(NUM_REQ);
    localparam sched_state_t POST_GEN = (WAIT_DRAIN != 0) ? DRAIN : DONE;

    sched_state_t       state_q, state_d;
    logic [PW-1:0]      rr_ptr, owner, grant_idx, rr_next;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    blit_desc_t         desc_q;
    blit_desc_t         req_desc_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_desc_arr[i] = bus.req_desc[i*BLIT_DESC_W +: BLIT_DESC_W];
    end

    blit_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept  = (state_q == IDLE) && (|bus.req_valid);
    assign rr_next = (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            desc_q  <= '0;
        end else begin
            state_q <= state_d;
            // Descriptor is captured only here so it stays frozen until the next accept.
            if (accept) begin
                desc_q <= req_desc_arr[grant_idx];
                owner  <= grant_idx;
`ifdef BLIT_SCHED_PRIORITY_EN
                if (grant_idx != '0) rr_ptr <= rr_next;
`else
                rr_ptr <= rr_next;
`endif
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        bus.gen_start = 1'b0;
        bus.done      = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = grant;
                if (|bus.req_valid) state_d = ISSUE;
            end
            ISSUE: begin
                // Dropping start in the ack cycle keeps a second start from being seen.
                bus.gen_start = ~bus.gen_ack;
                if (bus.gen_ack) state_d = bus.gen_busy ? RUN : POST_GEN;
            end
            RUN: begin
                if (!bus.gen_busy) state_d = POST_GEN;
            end
            DRAIN: begin
                if (bus.gen_pipe_idle) state_d = DONE;
            end
            DONE: begin
                bus.done = NUM_REQ'(1) << owner;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sched_busy = (state_q != IDLE);
    assign bus.gen_desc   = desc_q;

endmodule

// File: tb/tb_blit_cmd_scheduler.sv
// tb/tb_blit_cmd_scheduler.sv - directed self-checking bench for blit_cmd_scheduler
module tb_blit_cmd_scheduler;
    import blit_pkg::*;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    blit_cmd_scheduler_if #(.NUM_REQ(2)) bus ();

    blit_cmd_scheduler #(.NUM_REQ(2), .WAIT_DRAIN(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input logic [1:0] ready, input logic [1:0] dn,
                             input logic busy, input logic start);
        #1;
        chk({tag, "_ready"}, 256'(bus.req_ready), 256'(ready));
        chk({tag, "_done"},  256'(bus.done),      256'(dn));
        chk({tag, "_busy"},  256'(bus.sched_busy), 256'(busy));
        chk({tag, "_start"}, 256'(bus.gen_start),  256'(start));
    endtask

    task automatic chk_desc(input string tag, input blit_desc_t d);
        chk({tag, "_desc"}, 256'(bus.gen_desc), 256'(d));
    endtask

    function automatic blit_desc_t mk(input logic [4:0] cmd, input logic [15:0] x1, input logic [15:0] y1,
                                      input logic [15:0] x2, input logic [15:0] y2, input logic [31:0] salt);
        blit_desc_t d;
        d.command  = cmd;
        d.x1       = x1;
        d.y1       = y1;
        d.x2       = x2;
        d.y2       = y2;
        d.src_x    = salt[15:0];
        d.src_y    = ~salt[15:0];
        d.src_dx_x = salt;
        d.src_dy_y = ~salt;
        d.src_dy_x = salt ^ 32'h5a5a_a5a5;
        d.src_dx_y = {salt[15:0], salt[31:16]};
        return d;
    endfunction

    task automatic set_req(input int i, input blit_desc_t d);
        bus.req_desc[i*BLIT_DESC_W +: BLIT_DESC_W] = d;
    endtask

    blit_desc_t d1, d2, d3, d4;
    logic [1:0] next_valid;
    logic [1:0] exp_grant;
    int         waited;
    int         cnt0, cnt1;

    initial begin
        clock = 1'b0; reset_n = 1'b0; checks = 0; errors = 0;
        bus.req_valid = '0; bus.req_desc = '0;
        bus.gen_ack = 1'b0; bus.gen_busy = 1'b0; bus.gen_pipe_idle = 1'b1;
        d1 = mk(RECT, 16'd10, 16'd10, 16'd12, 16'd11, 32'h1111_0001);
        d2 = mk(RECT, 16'd5,  16'd5,  16'd5,  16'd9,  32'h2222_0002);
        d3 = mk(COPY, 16'd1,  16'd2,  16'd30, 16'd40, 32'h3333_0003);
        d4 = mk(TEXT, 16'd7,  16'd8,  16'd9,  16'd10, 32'h4444_0004);

        repeat (2) @(negedge clock);
        chk_cycle("reset", 2'b00, 2'b00, 1'b0, 1'b0);
        chk("reset_desc", 256'(bus.gen_desc), 256'd0);
        @(negedge clock); reset_n = 1'b1;

        // Single RECT, ack after three start cycles, busy for two cycles
        @(negedge clock); set_req(0, d1); bus.req_valid = 2'b01;
        chk_cycle("t2_acc", 2'b01, 2'b00, 1'b0, 1'b0);
        @(negedge clock); bus.req_valid = 2'b00;
        chk_cycle("t2_iss1", 2'b00, 2'b00, 1'b1, 1'b1); chk_desc("t2_iss1", d1);
        @(negedge clock); chk_cycle("t2_iss2", 2'b00, 2'b00, 1'b1, 1'b1);
        @(negedge clock); chk_cycle("t2_iss3", 2'b00, 2'b00, 1'b1, 1'b1);
        @(negedge clock); bus.gen_ack = 1'b1; bus.gen_busy = 1'b1;
        chk_cycle("t2_ack", 2'b00, 2'b00, 1'b1, 1'b0);
        @(negedge clock); bus.gen_ack = 1'b0;
        chk_cycle("t2_run1", 2'b00, 2'b00, 1'b1, 1'b0); chk_desc("t2_run1", d1);
        @(negedge clock); bus.gen_busy = 1'b0;
        chk_cycle("t2_run2", 2'b00, 2'b00, 1'b1, 1'b0);
        @(negedge clock); chk_cycle("t2_drain", 2'b00, 2'b00, 1'b1, 1'b0); chk_desc("t2_drain", d1);
        @(negedge clock); chk_cycle("t2_done", 2'b00, 2'b01, 1'b1, 1'b0);
        @(negedge clock); chk_cycle("t2_idle", 2'b00, 2'b00, 1'b0, 1'b0);

        // Degenerate rectangle: immediate ack with busy low
        @(negedge clock); set_req(0, d2); bus.req_valid = 2'b01;
        chk_cycle("t3_acc", 2'b01, 2'b00, 1'b0, 1'b0);
        @(negedge clock); bus.req_valid = 2'b00; bus.gen_ack = 1'b1; bus.gen_busy = 1'b0;
        chk_cycle("t3_ack", 2'b00, 2'b00, 1'b1, 1'b0); chk_desc("t3_ack", d2);
        @(negedge clock); bus.gen_ack = 1'b0;
        chk_cycle("t3_drain", 2'b00, 2'b00, 1'b1, 1'b0);
        @(negedge clock); chk_cycle("t3_done", 2'b00, 2'b01, 1'b1, 1'b0);
        @(negedge clock); chk_cycle("t3_idle", 2'b00, 2'b00, 1'b0, 1'b0);

        // Both requesters continuously valid, six grants each; rr_ptr is 1 here
        set_req(0, d1); set_req(1, d2); bus.gen_ack = 1'b1;
        next_valid = 2'b11; cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 12; i++) begin
            waited = 0;
            do begin
                @(negedge clock); bus.req_valid = next_valid; #1; waited++;
            end while (bus.req_ready == 2'b00 && waited < 8);
`ifdef BLIT_SCHED_PRIORITY_EN
            exp_grant = (i < 6) ? 2'b01 : 2'b10;
`else
            exp_grant = (i % 2 == 0) ? 2'b10 : 2'b01;
`endif
            chk("t4_grant", 256'(bus.req_ready), 256'(exp_grant));
            chk("t4_gap", 256'(waited), 256'((i == 0) ? 1 : 4));
            if (bus.req_ready[0]) cnt0++;
            if (bus.req_ready[1]) cnt1++;
            if (cnt0 >= 6) next_valid[0] = 1'b0;
            if (cnt1 >= 6) next_valid[1] = 1'b0;
        end
        @(negedge clock); bus.req_valid = 2'b00;
        repeat (3) @(negedge clock);
        bus.gen_ack = 1'b0;
        chk_cycle("t4_idle", 2'b00, 2'b00, 1'b0, 1'b0);

        // Drain wait: pipeline stays busy 20 cycles after generator busy falls
        @(negedge clock); set_req(1, d3); bus.req_valid = 2'b10;
        chk_cycle("t5_acc", 2'b10, 2'b00, 1'b0, 1'b0);
        @(negedge clock); bus.req_valid = 2'b00; bus.gen_ack = 1'b1; bus.gen_busy = 1'b1;
        chk_cycle("t5_ack", 2'b00, 2'b00, 1'b1, 1'b0); chk_desc("t5_ack", d3);
        @(negedge clock); bus.gen_ack = 1'b0;
        chk_cycle("t5_run", 2'b00, 2'b00, 1'b1, 1'b0);
        @(negedge clock); bus.gen_busy = 1'b0; bus.gen_pipe_idle = 1'b0;
        set_req(0, d4); bus.req_valid = 2'b01;
        chk_cycle("t5_busyfall", 2'b00, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock); chk_cycle("t5_drain", 2'b00, 2'b00, 1'b1, 1'b0);
        end
        @(negedge clock); bus.gen_pipe_idle = 1'b1;
        chk_cycle("t5_idlerise", 2'b00, 2'b00, 1'b1, 1'b0);
        @(negedge clock); chk_cycle("t5_done", 2'b00, 2'b10, 1'b1, 1'b0);

        // Contention after rr wrap, then a 50-cycle ack stall with req 1 churning its descriptor
        @(negedge clock); set_req(1, d1); bus.req_valid = 2'b11;
        chk_cycle("t6_acc", 2'b01, 2'b00, 1'b0, 1'b0);
        @(negedge clock); bus.req_valid = 2'b10;
        for (int k = 0; k < 50; k++) begin
            if (k > 0) @(negedge clock);
            set_req(1, mk(COPY, 16'(k), 16'(k + 1), 16'(k + 2), 16'(k + 3), 32'(k * 7919)));
            chk_cycle("t6_stall", 2'b00, 2'b00, 1'b1, 1'b1);
            chk_desc("t6_stall", d4);
        end
        @(negedge clock); bus.gen_ack = 1'b1; bus.gen_busy = 1'b0;
        chk_cycle("t6_ack", 2'b00, 2'b00, 1'b1, 1'b0); chk_desc("t6_ack", d4);
        @(negedge clock); bus.gen_ack = 1'b0;
        chk_cycle("t6_drain", 2'b00, 2'b00, 1'b1, 1'b0);
        @(negedge clock); chk_cycle("t6_done", 2'b00, 2'b01, 1'b1, 1'b0);

        // Reset while the generator is running
        @(negedge clock); set_req(1, d3);
        chk_cycle("t7_acc", 2'b10, 2'b00, 1'b0, 1'b0);
        @(negedge clock); bus.req_valid = 2'b00; bus.gen_ack = 1'b1; bus.gen_busy = 1'b1;
        chk_cycle("t7_ack", 2'b00, 2'b00, 1'b1, 1'b0); chk_desc("t7_ack", d3);
        @(negedge clock); bus.gen_ack = 1'b0;
        chk_cycle("t7_run", 2'b00, 2'b00, 1'b1, 1'b0);
        @(negedge clock); reset_n = 1'b0;
        chk_cycle("t7_rst", 2'b00, 2'b00, 1'b0, 1'b0);
        chk("t7_rst_desc", 256'(bus.gen_desc), 256'd0);
        @(negedge clock); reset_n = 1'b1;
        chk_cycle("t7_post", 2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); chk_cycle("t7_nodone", 2'b00, 2'b00, 1'b0, 1'b0);
        end
        @(negedge clock); bus.req_valid = 2'b11;
        chk_cycle("t7_rr_reset", 2'b01, 2'b00, 1'b0, 1'b0);
        @(negedge clock); bus.req_valid = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
